rr_arbiter16: RTL
=================

RR_ARBITER16 -- requirements
Module: rr_arbiter16

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8: maximum cycles one grant is held; 0 disables the timeout.
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port req, input, 16: request vector; bit i high means requester i wants the shared 16:1 mux.
REQ-005 SHALL have port done, input, 1: the granted requester's release pulse; ignored unless busy=1.
REQ-006 SHALL have port gnt, output, 16: one-hot grant, or all-zero when idle.
REQ-007 SHALL have port sel, output, 4: binary index of the granted requester; drives the 16:1 mux select.
REQ-008 SHALL have port busy, output, 1: high while a grant is held.
REQ-009 SHALL have port timeout, output, 1: one-cycle pulse when a grant is revoked by the hold limit.

Function
REQ-010 SHALL implement two states: IDLE and BUSY.
REQ-011 In IDLE with req != 0, the block SHALL select the first set req bit searching upward, with wrap, from index last+1.
- Next cycle: gnt = one-hot of the winner, sel = its index, busy = 1, last = winner, state = BUSY.
- Latency: request in IDLE at edge N gives a grant visible after edge N+1.
REQ-012 In IDLE with req == 0, the block SHALL keep gnt=0, busy=0 and hold sel at its previous value.
REQ-013 In BUSY, the block SHALL release the grant on any one of these conditions:
- done = 1;
- req[sel] = 0 (requester withdrew);
- hold counter reaches MAX_HOLD with MAX_HOLD != 0.
REQ-014 On release, the next cycle SHALL show gnt=0, busy=0 and state=IDLE; this one dead cycle is mandatory, and there is no back-to-back regrant.
REQ-015 The hold counter SHALL clear on grant and increment each BUSY cycle.
- Release by timeout occurs when the count equals MAX_HOLD-1, so the grant lasts exactly MAX_HOLD cycles.
- The counter SHALL be wide enough for MAX_HOLD without overflow.
REQ-016 timeout SHALL pulse high for exactly the one cycle following a timeout release.
- If done or a withdrawal coincides with expiry, the release SHALL be treated as normal and timeout SHALL stay 0.
REQ-017 sel SHALL remain stable during BUSY; changes to requests other than req[sel] SHALL NOT affect gnt or sel.
REQ-018 The pointer last SHALL update only on a grant.
- Fairness: with all 16 requesting and each grant released, grants SHALL cycle 0,1,...,15,0.
REQ-019 gnt SHALL never have more than one bit set; gnt[sel] = busy at all times.

Reset
REQ-020 While rst=1, the block SHALL force the following, regardless of clk:
- state = IDLE;
- gnt = 0, sel = 0, busy = 0, timeout = 0;
- hold counter = 0;
- last = 15, so requester 0 has first priority.
REQ-021 Reset asserted mid-grant SHALL drop the grant immediately (asynchronously), and the first arbitration after reset SHALL again favour index 0.

Structure
REQ-022 A shared package SHALL hold:
- N_REQ = 16, SEL_W = 4;
- the state encoding constants IDLE/BUSY.
REQ-023 The round-robin search SHALL be one combinational sub-module, rr_priority_pick.
- Inputs: req[15:0], last[3:0]. Outputs: found, idx[3:0].
- It SHALL be instantiated once; all registers stay in rr_arbiter16.

Verification
REQ-024 Reset then req=16'h0001 -> gnt=16'h0001, sel=0, busy=1 one cycle after req is sampled; done pulse -> gnt=0, busy=0 next cycle.
REQ-025 req=16'hFFFF held, done pulsed one cycle after each grant -> sel sequence 0,1,2,...,15,0, with one idle cycle between grants.
REQ-026 MAX_HOLD=8, req=16'h0010 held, no done -> gnt=16'h0010 for exactly 8 cycles, then gnt=0 and a single-cycle timeout pulse.
REQ-027 Grant to index 3, then req[3] drops while req=16'h8008 becomes 16'h8000 -> release next cycle, then grant to 15; after release, req=16'h0009 -> grant to 0 (wrap).
REQ-028 rst asserted while busy with sel=7 -> gnt=0, busy=0, sel=0 without a clock edge; after release with req=16'h0081 -> grant to 0, not 7.

Source files
------------

// File: rtl/rr_arbiter16_pkg.sv
// Shared constants, state encoding and helpers for the 16-way round-robin arbiter.
// Imported by the arbiter top and its priority-pick sub-module.
package rr_arbiter16_pkg;

  localparam int N_REQ = 16;
  localparam int SEL_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Pointer value after reset: search starts at last+1, so requester 0 wins first.
  localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(N_REQ - 1);

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_arbiter16_pick.sv
// Combinational round-robin search: first set req bit upward from last+1, wrapping.
// Zero latency; no flow control (pure function of req and last).
module rr_priority_pick
  import rr_arbiter16_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] last,
  output logic             found,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Offsets 1..N_REQ; the 4-bit add wraps, and offset N_REQ revisits last itself.
  always_comb begin
    found = 1'b0;
    idx   = last;
    cand  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = last + SEL_W'(i);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter16.sv
// 16:1 round-robin arbiter with hold timeout; grant registered one edge after request.
// Release on done, withdrawal or hold limit, always followed by one idle cycle.
module rr_arbiter16
  import rr_arbiter16_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             timeout
);

  localparam int HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HOLD_W'(MAX_HOLD - 1) : '0;

  state_t           state;
  logic [SEL_W-1:0] last;
  logic [HOLD_W-1:0] hold_cnt;

  logic             pick_found;
  logic [SEL_W-1:0] pick_idx;
  logic             owner_req;
  logic             expired;
  logic             release_now;

  rr_priority_pick u_pick (
    .req   (req),
    .last  (last),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign owner_req   = req[sel];
  assign expired     = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  assign release_now = done || !owner_req || expired;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      sel      <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
      last     <= LAST_RST;
    end else begin
      case (state)
        IDLE: begin
          timeout <= 1'b0;
          if (pick_found) begin
            gnt      <= onehot(pick_idx);
            sel      <= pick_idx;
            busy     <= 1'b1;
            last     <= pick_idx;
            hold_cnt <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (release_now) begin
            gnt     <= '0;
            busy    <= 1'b0;
            state   <= IDLE;
            // A timeout is only flagged when the limit alone ended the grant.
            timeout <= expired && !done && owner_req;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
            timeout  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
